tlb_walk_ctrl: RTL and testbench

- TLB miss controller between the TLB and the memory side.
- Arbitrates miss requests from the instruction-fetch port and the load/store port of the TLB.
- Performs a two-level Sv32 page-table walk over a single-outstanding memory read port.
- Returns either a one-cycle refill write into the TLB or a one-cycle fault indication to the requesting port.

---
 rtl/tlb_pkg.sv | 55 +++++
 rtl/tlb_rr_arb2.sv | 42 ++++
 rtl/tlb_walk_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_tlb_walk_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared Sv32 walk definitions: field widths, PTE bit positions, state encoding,
// port IDs, the PTE payload layout and the PTE address helper.
package tlb_pkg;

    localparam int unsigned SV32_VPN_W      = 20;
    localparam int unsigned SV32_PPN_W      = 22;
    localparam int unsigned SV32_PADDR_W    = 34;
    localparam int unsigned SV32_PTE_W      = 32;
    localparam int unsigned SV32_VPN_PART_W = 10;
    localparam int unsigned SV32_PAGE_OFS_W = 12;
    localparam int unsigned PERM_W          = 4;

    localparam int unsigned PTE_V_BIT   = 0;
    localparam int unsigned PTE_R_BIT   = 1;
    localparam int unsigned PTE_W_BIT   = 2;
    localparam int unsigned PTE_X_BIT   = 3;
    localparam int unsigned PTE_U_BIT   = 4;
    localparam int unsigned PTE_PPN_LSB = 10;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_REQ  = 3'd1,
        ST_L1_WAIT = 3'd2,
        ST_L0_REQ  = 3'd3,
        ST_L0_WAIT = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAULT   = 3'd6
    } walk_state_e;

    // Sv32 PTE layout, MSB first; matches the PTE_*_BIT positions above.
    typedef struct packed {
        logic [SV32_PPN_W-1:0] ppn;
        logic [1:0]            rsw;
        logic                  d;
        logic                  a;
        logic                  g;
        logic                  u;
        logic                  x;
        logic                  w;
        logic                  r;
        logic                  v;
    } pte_t;

    // Physical address of PTE number idx inside the table page base_ppn.
    function automatic logic [SV32_PADDR_W-1:0] pte_addr(
        input logic [SV32_PPN_W-1:0]      base_ppn,
        input logic [SV32_VPN_PART_W-1:0] idx
    );
        return {base_ppn, {SV32_PAGE_OFS_W{1'b0}}} + SV32_PADDR_W'({idx, 2'b00});
    endfunction

endpackage

// File: rtl/tlb_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req_i      : request vector, bit 0 = fetch, bit 1 = load/store
//   en_i       : arbitration allowed this cycle
//   gnt_c_o    : one-hot combinational grant
module tlb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_c_o
);

    // ptr_q = 0 favours requester 0, 1 favours requester 1.
    logic ptr_q;
    logic ptr_d;

    // Grant select; after any grant the pointer moves to the other requester.
    always_comb begin
        gnt_c_o = 2'b00;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_c_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt_c_o = req_i;
            end
        end
        if (|gnt_c_o) begin
            ptr_d = gnt_c_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tlb_walk_ctrl.sv
// TLB miss controller: arbitrates fetch and load/store misses, walks the Sv32
// two-level page table over a single-outstanding memory port, and returns a
// one-cycle refill or fault pulse.
//   satp_mode/satp_ppn         : translation mode and root table PPN
//   flush                      : abort any walk in progress
//   if_miss_* / ls_miss_*      : miss requests; *_ready pulses on accept
//   mem_req_* / mem_resp_*     : PTE read request / response
//   refill_*                   : TLB write pulse and entry contents
//   fault_*                    : page-fault pulse
//   busy                       : walk FSM not idle
module tlb_walk_ctrl
    import tlb_pkg::*;
#(
    parameter int unsigned VPN_W   = SV32_VPN_W,
    parameter int unsigned PPN_W   = SV32_PPN_W,
    parameter int unsigned PADDR_W = SV32_PADDR_W,
    parameter int unsigned PTE_W   = SV32_PTE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               satp_mode,
    input  logic [PPN_W-1:0]   satp_ppn,
    input  logic               flush,
    input  logic               if_miss_valid,
    input  logic [VPN_W-1:0]   if_miss_vpn,
    output logic               if_miss_ready,
    input  logic               ls_miss_valid,
    input  logic [VPN_W-1:0]   ls_miss_vpn,
    output logic               ls_miss_ready,
    output logic               mem_req_valid,
    output logic [PADDR_W-1:0] mem_req_addr,
    input  logic               mem_req_ready,
    input  logic               mem_resp_valid,
    input  logic [PTE_W-1:0]   mem_resp_data,
    output logic               refill_valid,
    output logic               refill_port,
    output logic [VPN_W-1:0]   refill_vpn,
    output logic [PPN_W-1:0]   refill_ppn,
    output logic [3:0]         refill_perm,
    output logic               refill_super,
    output logic               fault_valid,
    output logic               fault_port,
    output logic [VPN_W-1:0]   fault_vpn,
    output logic               busy
);

    walk_state_e        state_q, state_d;
    logic               abort_q, abort_d;
    logic               port_q, port_d;
    logic [VPN_W-1:0]   vpn_q, vpn_d;
    logic [PPN_W-1:0]   res_ppn_q, res_ppn_d;
    logic [3:0]         res_perm_q, res_perm_d;
    logic               res_super_q, res_super_d;

    logic               if_ready_q, if_ready_d;
    logic               ls_ready_q, ls_ready_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic [PADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic               refill_valid_q, refill_valid_d;
    logic               refill_port_q, refill_port_d;
    logic [VPN_W-1:0]   refill_vpn_q, refill_vpn_d;
    logic [PPN_W-1:0]   refill_ppn_q, refill_ppn_d;
    logic [3:0]         refill_perm_q, refill_perm_d;
    logic               refill_super_q, refill_super_d;
    logic               fault_valid_q, fault_valid_d;
    logic               fault_port_q, fault_port_d;
    logic [VPN_W-1:0]   fault_vpn_q, fault_vpn_d;
    logic               busy_q, busy_d;

    logic [1:0]         gnt_c;
    logic               arb_en_c;
    logic [VPN_W-1:0]   sel_vpn_c;
    logic               abort_now_c;
    pte_t               pte_c;
    logic               pte_bad_c;
    logic               pte_leaf_c;
    logic               pte_misaligned_c;
    logic [3:0]         pte_perm_c;
    logic               unused_pte_bits;

    // Arbitration only happens from IDLE; flush blocks acceptance that cycle.
    assign arb_en_c = (state_q == ST_IDLE) && !flush;

    tlb_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   ({ls_miss_valid, if_miss_valid}),
        .en_i    (arb_en_c),
        .gnt_c_o (gnt_c)
    );

    assign sel_vpn_c = gnt_c[1] ? ls_miss_vpn : if_miss_vpn;

    // A flush seen in the same cycle as a response must already drop it.
    assign abort_now_c = abort_q | flush;

    // PTE decode of the current response.
    assign pte_c            = pte_t'(mem_resp_data);
    assign pte_bad_c        = !pte_c.v || (pte_c.w && !pte_c.r);
    assign pte_leaf_c       = pte_c.r || pte_c.x;
    assign pte_misaligned_c = (pte_c.ppn[SV32_VPN_PART_W-1:0] != '0);
    assign pte_perm_c       = {pte_c.u, pte_c.x, pte_c.w, pte_c.r};
    assign unused_pte_bits  = ^{pte_c.rsw, pte_c.d, pte_c.a, pte_c.g};

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        abort_d         = abort_q;
        port_d          = port_q;
        vpn_d           = vpn_q;
        res_ppn_d       = res_ppn_q;
        res_perm_d      = res_perm_q;
        res_super_d     = res_super_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        if_ready_d      = 1'b0;
        ls_ready_d      = 1'b0;
        refill_valid_d  = 1'b0;
        refill_port_d   = 1'b0;
        refill_vpn_d    = '0;
        refill_ppn_d    = '0;
        refill_perm_d   = '0;
        refill_super_d  = 1'b0;
        fault_valid_d   = 1'b0;
        fault_port_d    = 1'b0;
        fault_vpn_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (|gnt_c) begin
                    port_d     = gnt_c[1] ? PORT_LS : PORT_IF;
                    vpn_d      = sel_vpn_c;
                    if_ready_d = gnt_c[0];
                    ls_ready_d = gnt_c[1];
                    if (!satp_mode) begin
                        state_d     = ST_DONE;
                        res_ppn_d   = PPN_W'(sel_vpn_c);
                        res_perm_d  = 4'b0111;
                        res_super_d = 1'b0;
                    end else begin
                        state_d         = ST_L1_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = pte_addr(satp_ppn,
                                                   sel_vpn_c[VPN_W-1:SV32_VPN_PART_W]);
                    end
                end
            end
            ST_L1_REQ, ST_L0_REQ: begin
                // Request is never withdrawn, even under abort.
                abort_d = abort_now_c;
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L0_WAIT;
                end
            end
            ST_L1_WAIT: begin
                abort_d = abort_now_c;
                if (mem_resp_valid) begin
                    if (abort_now_c) begin
                        state_d = ST_IDLE;
                    end else if (pte_bad_c) begin
                        state_d = ST_FAULT;
                    end else if (pte_leaf_c) begin
                        if (pte_misaligned_c) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d     = ST_DONE;
                            res_super_d = 1'b1;
                            res_perm_d  = pte_perm_c;
                            res_ppn_d   = {pte_c.ppn[PPN_W-1:SV32_VPN_PART_W],
                                           vpn_q[SV32_VPN_PART_W-1:0]};
                        end
                    end else begin
                        state_d         = ST_L0_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = pte_addr(pte_c.ppn,
                                                   vpn_q[SV32_VPN_PART_W-1:0]);
                    end
                end
            end
            ST_L0_WAIT: begin
                abort_d = abort_now_c;
                if (mem_resp_valid) begin
                    if (abort_now_c) begin
                        state_d = ST_IDLE;
                    end else if (pte_bad_c || !pte_leaf_c) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d     = ST_DONE;
                        res_super_d = 1'b0;
                        res_perm_d  = pte_perm_c;
                        res_ppn_d   = pte_c.ppn;
                    end
                end
            end
            ST_DONE: begin
                state_d        = ST_IDLE;
                refill_valid_d = 1'b1;
                refill_port_d  = port_q;
                refill_vpn_d   = vpn_q;
                refill_ppn_d   = res_ppn_q;
                refill_perm_d  = res_perm_q;
                refill_super_d = res_super_q;
            end
            ST_FAULT: begin
                state_d       = ST_IDLE;
                fault_valid_d = 1'b1;
                fault_port_d  = port_q;
                fault_vpn_d   = vpn_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            abort_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            abort_q         <= 1'b0;
            port_q          <= 1'b0;
            vpn_q           <= '0;
            res_ppn_q       <= '0;
            res_perm_q      <= '0;
            res_super_q     <= 1'b0;
            if_ready_q      <= 1'b0;
            ls_ready_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            refill_valid_q  <= 1'b0;
            refill_port_q   <= 1'b0;
            refill_vpn_q    <= '0;
            refill_ppn_q    <= '0;
            refill_perm_q   <= '0;
            refill_super_q  <= 1'b0;
            fault_valid_q   <= 1'b0;
            fault_port_q    <= 1'b0;
            fault_vpn_q     <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            abort_q         <= abort_d;
            port_q          <= port_d;
            vpn_q           <= vpn_d;
            res_ppn_q       <= res_ppn_d;
            res_perm_q      <= res_perm_d;
            res_super_q     <= res_super_d;
            if_ready_q      <= if_ready_d;
            ls_ready_q      <= ls_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            refill_valid_q  <= refill_valid_d;
            refill_port_q   <= refill_port_d;
            refill_vpn_q    <= refill_vpn_d;
            refill_ppn_q    <= refill_ppn_d;
            refill_perm_q   <= refill_perm_d;
            refill_super_q  <= refill_super_d;
            fault_valid_q   <= fault_valid_d;
            fault_port_q    <= fault_port_d;
            fault_vpn_q     <= fault_vpn_d;
            busy_q          <= busy_d;
        end
    end

    assign if_miss_ready = if_ready_q;
    assign ls_miss_ready = ls_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign refill_valid  = refill_valid_q;
    assign refill_port   = refill_port_q;
    assign refill_vpn    = refill_vpn_q;
    assign refill_ppn    = refill_ppn_q;
    assign refill_perm   = refill_perm_q;
    assign refill_super  = refill_super_q;
    assign fault_valid   = fault_valid_q;
    assign fault_port    = fault_port_q;
    assign fault_vpn     = fault_vpn_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_tlb_walk_ctrl.sv
// Directed bench for tlb_walk_ctrl: inputs driven and outputs sampled on the
// falling clock edge, expected values hand-computed from the Sv32 rules.
module tb_tlb_walk_ctrl;

    logic        clk;
    logic        rst_n;
    logic        satp_mode;
    logic [21:0] satp_ppn;
    logic        flush;
    logic        if_miss_valid;
    logic [19:0] if_miss_vpn;
    logic        if_miss_ready;
    logic        ls_miss_valid;
    logic [19:0] ls_miss_vpn;
    logic        ls_miss_ready;
    logic        mem_req_valid;
    logic [33:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        refill_valid;
    logic        refill_port;
    logic [19:0] refill_vpn;
    logic [21:0] refill_ppn;
    logic [3:0]  refill_perm;
    logic        refill_super;
    logic        fault_valid;
    logic        fault_port;
    logic [19:0] fault_vpn;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int ready_cnt = 0;
    int ready_base = 0;

    tlb_walk_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .satp_mode      (satp_mode),
        .satp_ppn       (satp_ppn),
        .flush          (flush),
        .if_miss_valid  (if_miss_valid),
        .if_miss_vpn    (if_miss_vpn),
        .if_miss_ready  (if_miss_ready),
        .ls_miss_valid  (ls_miss_valid),
        .ls_miss_vpn    (ls_miss_vpn),
        .ls_miss_ready  (ls_miss_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .refill_valid   (refill_valid),
        .refill_port    (refill_port),
        .refill_vpn     (refill_vpn),
        .refill_ppn     (refill_ppn),
        .refill_perm    (refill_perm),
        .refill_super   (refill_super),
        .fault_valid    (fault_valid),
        .fault_port     (fault_port),
        .fault_vpn      (fault_vpn),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every ready pulse seen, for the one-grant-per-walk check.
    always @(negedge clk) begin
        ready_cnt <= ready_cnt + int'(if_miss_ready) + int'(ls_miss_ready);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Serve one PTE read: accept now, respond on the following cycle.
    task automatic serve(input string tag, input logic [33:0] addr, input logic [31:0] data);
        check({tag, "_req_valid"}, 128'(mem_req_valid), 128'(1));
        check({tag, "_req_addr"}, 128'(mem_req_addr), 128'(addr));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        step();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        satp_mode      = 1'b1;
        satp_ppn       = 22'h10;
        flush          = 1'b0;
        if_miss_valid  = 1'b0;
        if_miss_vpn    = '0;
        ls_miss_valid  = 1'b0;
        ls_miss_vpn    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // Reset state
        #12;
        check("rst_pulses", 128'({if_miss_ready, ls_miss_ready, refill_valid, fault_valid, mem_req_valid, busy}), 128'(0));
        check("rst_refill", 128'({refill_port, refill_vpn, refill_ppn, refill_perm, refill_super}), 128'(0));
        check("rst_fault_mem", 128'({fault_port, fault_vpn, mem_req_addr}), 128'(0));
        step();
        rst_n = 1'b1;

        // Sv32 two-level walk from the fetch port
        if_miss_valid = 1'b1;
        if_miss_vpn   = 20'h12345;
        step();
        check("walk_if_ready", 128'({ls_miss_ready, if_miss_ready}), 128'(2'b01));
        check("walk_busy", 128'(busy), 128'(1));
        if_miss_valid = 1'b0;
        serve("walk_l1", 34'h10120, 32'h0000_8001);
        serve("walk_l0", 34'h20D14, 32'h0000_C00F);
        check("walk_no_early_refill", 128'(refill_valid), 128'(0));
        step();
        check("walk_refill_valid", 128'(refill_valid), 128'(1));
        check("walk_refill_entry", 128'({refill_port, refill_vpn, refill_ppn, refill_perm, refill_super}),
              128'({1'b0, 20'h12345, 22'h030, 4'b0111, 1'b0}));
        check("walk_no_fault", 128'(fault_valid), 128'(0));
        step();
        check("walk_refill_clear", 128'({refill_valid, refill_ppn, busy}), 128'(0));

        // 4 MiB superpage: one memory access only
        if_miss_valid = 1'b1;
        step();
        check("super_ready", 128'(if_miss_ready), 128'(1));
        if_miss_valid = 1'b0;
        serve("super_l1", 34'h10120, 32'h0040_0007);
        check("super_one_access", 128'(mem_req_valid), 128'(0));
        step();
        check("super_refill", 128'({refill_valid, refill_port, refill_vpn, refill_ppn, refill_perm, refill_super}),
              128'({1'b1, 1'b0, 20'h12345, 22'h1345, 4'b0011, 1'b1}));
        step();

        // Misaligned superpage fault on the load/store port
        ls_miss_valid = 1'b1;
        ls_miss_vpn   = 20'h12345;
        step();
        check("misal_ls_ready", 128'({ls_miss_ready, if_miss_ready}), 128'(2'b10));
        ls_miss_valid = 1'b0;
        serve("misal_l1", 34'h10120, 32'h0000_0C03);
        step();
        check("misal_fault", 128'({fault_valid, fault_port, fault_vpn}), 128'({1'b1, 1'b1, 20'h12345}));
        check("misal_no_refill", 128'(refill_valid), 128'(0));
        step();
        check("misal_fault_clear", 128'({fault_valid, fault_port, fault_vpn}), 128'(0));

        // Invalid level-1 PTE
        if_miss_valid = 1'b1;
        if_miss_vpn   = 20'h00401;
        step();
        if_miss_valid = 1'b0;
        serve("inval_l1", 34'h10004, 32'h0000_0000);
        step();
        check("inval_fault", 128'({fault_valid, fault_port, fault_vpn}), 128'({1'b1, 1'b0, 20'h00401}));
        step();

        // Non-leaf PTE at level 0
        if_miss_valid = 1'b1;
        if_miss_vpn   = 20'h12345;
        step();
        if_miss_valid = 1'b0;
        serve("nl0_l1", 34'h10120, 32'h0000_8001);
        serve("nl0_l0", 34'h20D14, 32'h0000_8001);
        step();
        check("nl0_fault", 128'({fault_valid, refill_valid}), 128'(2'b10));
        step();

        // Flush in L1_WAIT: response drained, no L0 request, no pulse
        if_miss_valid = 1'b1;
        step();
        if_miss_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        flush         = 1'b1;
        step();
        flush = 1'b0;
        check("flw_busy_hold", 128'(busy), 128'(1));
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_8001;
        step();
        mem_resp_valid = 1'b0;
        check("flw_drained", 128'({busy, mem_req_valid, refill_valid, fault_valid}), 128'(0));
        step();
        check("flw_quiet", 128'({busy, mem_req_valid, refill_valid, fault_valid}), 128'(0));

        // Flush in L1_REQ with a slow memory: request held until accepted
        if_miss_valid = 1'b1;
        step();
        if_miss_valid = 1'b0;
        flush         = 1'b1;
        step();
        flush = 1'b0;
        check("flr_req_held", 128'({mem_req_valid, mem_req_addr}), 128'({1'b1, 34'h10120}));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("flr_wait_busy", 128'({mem_req_valid, busy}), 128'(2'b01));
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0C03;
        step();
        mem_resp_valid = 1'b0;
        check("flr_drained", 128'({busy, mem_req_valid, fault_valid}), 128'(0));
        step();
        check("flr_quiet", 128'({refill_valid, fault_valid, mem_req_valid}), 128'(0));

        // Flush in IDLE blocks acceptance; stray response ignored; then bare mode
        satp_mode      = 1'b0;
        flush          = 1'b1;
        mem_resp_valid = 1'b1;
        if_miss_valid  = 1'b1;
        if_miss_vpn    = 20'hABCDE;
        step();
        check("fli_no_grant", 128'({if_miss_ready, busy}), 128'(0));
        flush          = 1'b0;
        mem_resp_valid = 1'b0;
        step();
        check("bare_grant", 128'({if_miss_ready, busy, mem_req_valid}), 128'(3'b110));
        if_miss_valid = 1'b0;
        step();
        check("bare_refill", 128'({refill_valid, refill_port, refill_vpn, refill_ppn, refill_perm, refill_super}),
              128'({1'b1, 1'b0, 20'hABCDE, 22'h0ABCDE, 4'b0111, 1'b0}));
        check("bare_no_mem", 128'(mem_req_valid), 128'(0));
        step();
        satp_mode = 1'b1;

        // Reset asserted during L0_WAIT
        if_miss_valid = 1'b1;
        if_miss_vpn   = 20'h12345;
        step();
        if_miss_valid = 1'b0;
        serve("mrst_l1", 34'h10120, 32'h0000_8001);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("mrst_pre_busy", 128'(busy), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mrst_outs", 128'({if_miss_ready, ls_miss_ready, mem_req_valid, refill_valid, fault_valid, busy}), 128'(0));
        check("mrst_addr", 128'(mem_req_addr), 128'(0));
        step();
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_C00F;
        step();
        mem_resp_valid = 1'b0;
        check("mrst_resp_ignored", 128'({busy, refill_valid, fault_valid, mem_req_valid}), 128'(0));

        // Both ports valid continuously from reset: IF, LS, IF
        rst_n         = 1'b0;
        if_miss_valid = 1'b1;
        if_miss_vpn   = 20'h00401;
        ls_miss_valid = 1'b1;
        ls_miss_vpn   = 20'h00802;
        step();
        rst_n = 1'b1;
        #2 ready_base = ready_cnt;
        for (int w = 0; w < 3; w++) begin
            step();
            check($sformatf("arb_grant%0d", w), 128'({ls_miss_ready, if_miss_ready}),
                  128'((w % 2 == 0) ? 2'b01 : 2'b10));
            serve($sformatf("arb_l1_%0d", w), (w % 2 == 0) ? 34'h10004 : 34'h10008, 32'h0);
            check($sformatf("arb_busy_nogrant%0d", w), 128'({ls_miss_ready, if_miss_ready, busy}), 128'(3'b001));
            step();
            check($sformatf("arb_fault%0d", w), 128'({fault_valid, fault_port, fault_vpn}),
                  128'({1'b1, (w % 2 == 0) ? 1'b0 : 1'b1, (w % 2 == 0) ? 20'h00401 : 20'h00802}));
        end
        if_miss_valid = 1'b0;
        ls_miss_valid = 1'b0;
        #2;
        check("arb_ready_count", 128'(ready_cnt - ready_base), 128'(3));
        step();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
